// File: rtl/sound_dac_mixer_pkg.sv
// Shared definitions for the PCM/beeper mixer and its 1-bit modulators.
// Holds default geometry, beeper/tapeout data-bit positions, modulator
// mode encoding and the per-side sum width helper.
package sound_dac_mixer_pkg;

  localparam int unsigned NCH_DEF  = 4;
  localparam int unsigned DW_DEF   = 8;

  // din bit positions for the beeper and tapeout sources
  localparam int unsigned BEEP_BIT = 4;
  localparam int unsigned TAPE_BIT = 3;

  typedef enum logic {
    MODE_PWM = 1'b0,
    MODE_SD  = 1'b1
  } mode_e;

  // Width of one side's sum: NCH/2 samples of dw bits never overflow it
  function automatic int unsigned sum_width(input int unsigned nch, input int unsigned dw);
    return dw + int'($clog2(nch / 2));
  endfunction

endpackage

// File: rtl/sound_dac_mixer_if.sv
// CPU-side write strobes and 1-bit sound outputs of the mixer.
//   master: port decoder side (drives din/strobes/mode, reads outputs)
//   slave : mixer side
interface sound_dac_mixer_if
  import sound_dac_mixer_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEF,
  parameter int unsigned DW  = DW_DEF
);

  logic [DW-1:0]  din;
  logic [NCH-1:0] ch_wr;
  logic           beeper_wr;
  logic           beeper_mux;
  logic           mode_sd;
  logic           beep_act;
  logic           snd_l;
  logic           snd_r;

  modport master (
    output din, ch_wr, beeper_wr, beeper_mux, mode_sd,
    input  beep_act, snd_l, snd_r
  );

  modport slave (
    input  din, ch_wr, beeper_wr, beeper_mux, mode_sd,
    output beep_act, snd_l, snd_r
  );

endinterface

// File: rtl/sound_dac_mixer_mod1b.sv
// One-side 1-bit modulator: PWM compare against the shared period counter,
// or first-order sigma-delta whose carry is the output bit.
// Ports: clk, rst_n; ctr (shared period counter); mode_q (latched mode);
//        sum (registered side sum); snd (registered 1-bit output).
module sound_dac_mixer_mod1b
  import sound_dac_mixer_pkg::*;
#(
  parameter int unsigned SW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [SW-1:0] ctr,
  input  mode_e         mode_q,
  input  logic [SW-1:0] sum,
  output logic          snd
);

  // Only the low SW bits of the accumulator persist; the carry goes out as snd
  logic [SW-1:0] acc;
  logic [SW:0]   acc_nxt_c;

  assign acc_nxt_c = {1'b0, acc} + {1'b0, sum};

  // Accumulator is held at zero in PWM so SD always starts from a clean state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      snd <= 1'b0;
    end else if (mode_q == MODE_SD) begin
      acc <= acc_nxt_c[SW-1:0];
      snd <= acc_nxt_c[SW];
    end else begin
      acc <= '0;
      snd <= (ctr < sum);
    end
  end

endmodule

// File: rtl/sound_dac_mixer.sv
// Multi-channel PCM plus beeper/tapeout mixer with 1-bit stereo DAC outputs.
// Ports: clk, rst_n (async, active low); bus (slave modport) carrying din,
//        ch_wr, beeper_wr, beeper_mux, mode_sd in and beep_act, snd_l, snd_r out.
// Even channels mix to the left side, odd channels to the right.
module sound_dac_mixer
  import sound_dac_mixer_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEF,
  parameter int unsigned DW  = DW_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  sound_dac_mixer_if.slave   bus
);

  localparam int unsigned SW = sum_width(NCH, DW);

  logic [DW-1:0] val [NCH];
  logic          beep_bit;
  logic          beep_act;
  logic          beep_new_c;
  logic [SW-1:0] sum_l, sum_r;
  logic [SW-1:0] sum_l_c, sum_r_c;
  logic [SW-1:0] ctr;
  mode_e         mode_q;
  logic          snd_l, snd_r;

  assign beep_new_c = bus.beeper_mux ? bus.din[TAPE_BIT] : bus.din[BEEP_BIT];

  // Sample registers and beeper/PCM mode latch; a changing beep bit wins over PCM writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NCH); i++) val[i] <= '0;
      beep_bit <= 1'b0;
      beep_act <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NCH); i++) begin
        if (bus.ch_wr[i]) val[i] <= bus.din;
      end
      if (bus.beeper_wr) beep_bit <= beep_new_c;
      if (bus.beeper_wr && (beep_new_c != beep_bit)) beep_act <= 1'b1;
      else if (|bus.ch_wr)                           beep_act <= 1'b0;
    end
  end

  // Per-side sums; beeper mode drives both sides to full scale or zero
  always_comb begin
    sum_l_c = '0;
    sum_r_c = '0;
    if (beep_act) begin
      sum_l_c = {SW{beep_bit}};
      sum_r_c = {SW{beep_bit}};
    end else begin
      for (int i = 0; i < int'(NCH); i += 2) begin
        sum_l_c = sum_l_c + SW'(val[i]);
        sum_r_c = sum_r_c + SW'(val[i+1]);
      end
    end
  end

  // Sum stage, free-running period counter, mode latched only at the wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_l  <= '0;
      sum_r  <= '0;
      ctr    <= '0;
      mode_q <= MODE_PWM;
    end else begin
      sum_l <= sum_l_c;
      sum_r <= sum_r_c;
      ctr   <= ctr + SW'(1);
      if (ctr == {SW{1'b1}}) mode_q <= mode_e'(bus.mode_sd);
    end
  end

  sound_dac_mixer_mod1b #(.SW(SW)) u_mod_l (
    .clk    (clk),
    .rst_n  (rst_n),
    .ctr    (ctr),
    .mode_q (mode_q),
    .sum    (sum_l),
    .snd    (snd_l)
  );

  sound_dac_mixer_mod1b #(.SW(SW)) u_mod_r (
    .clk    (clk),
    .rst_n  (rst_n),
    .ctr    (ctr),
    .mode_q (mode_q),
    .sum    (sum_r),
    .snd    (snd_r)
  );

  assign bus.beep_act = beep_act;
  assign bus.snd_l    = snd_l;
  assign bus.snd_r    = snd_r;

endmodule

// File: tb/tb_sound_dac_mixer.sv
// Scoreboard bench for sound_dac_mixer: every driven cycle pushes the expected
// {snd_l, snd_r, beep_act} from an arithmetic reference model; a monitor pops
// and compares after each clock edge. Directed phases add per-period counts.
module tb_sound_dac_mixer;

  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int SW  = DW + $clog2(NCH / 2);
  localparam int TOP = 1 << SW;

  logic clk;
  logic rst_n;
  logic cur_mux;
  logic cur_msd;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] exp_q[$];
  logic [2:0] mon_e;

  // reference model state
  int m_val[NCH];
  bit m_bit, m_act, m_mode;
  int m_sum_l, m_sum_r, m_ctr, m_acc_l, m_acc_r;

  sound_dac_mixer_if #(.NCH(NCH), .DW(DW)) sif ();

  sound_dac_mixer #(.NCH(NCH), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) m_val[i] = 0;
    m_bit = 0; m_act = 0; m_mode = 0;
    m_sum_l = 0; m_sum_r = 0; m_ctr = 0; m_acc_l = 0; m_acc_r = 0;
  endtask

  // Outputs at an edge come from the period position, mode and sum held before it;
  // sums come from samples held before it; inputs update samples and beep state.
  task automatic model_step(input logic [DW-1:0] d, input logic [NCH-1:0] wr,
                            input logic bw, input logic bm, input logic msd);
    bit o_l, o_r, nb;
    int s_l, s_r;
    if (m_mode) begin
      m_acc_l = (m_acc_l % TOP) + m_sum_l;
      m_acc_r = (m_acc_r % TOP) + m_sum_r;
      o_l = (m_acc_l >= TOP);
      o_r = (m_acc_r >= TOP);
    end else begin
      m_acc_l = 0;
      m_acc_r = 0;
      o_l = (m_ctr < m_sum_l);
      o_r = (m_ctr < m_sum_r);
    end
    s_l = 0;
    s_r = 0;
    for (int i = 0; i < NCH; i++) begin
      if (i % 2 == 0) s_l += m_val[i];
      else            s_r += m_val[i];
    end
    if (m_act) begin
      s_l = m_bit ? TOP - 1 : 0;
      s_r = s_l;
    end
    m_sum_l = s_l;
    m_sum_r = s_r;
    if (m_ctr == TOP - 1) m_mode = msd;
    m_ctr = (m_ctr + 1) % TOP;
    nb = bm ? d[3] : d[4];
    if (bw && (nb != m_bit)) m_act = 1;
    else if (wr != '0)       m_act = 0;
    if (bw) m_bit = nb;
    for (int i = 0; i < NCH; i++) if (wr[i]) m_val[i] = int'(d);
    exp_q.push_back({o_l, o_r, m_act});
  endtask

  // Drive one cycle of inputs at the falling edge and queue its expectation
  task automatic cycle(input logic [DW-1:0] d, input logic [NCH-1:0] wr, input logic bw);
    @(negedge clk);
    sif.din        = d;
    sif.ch_wr      = wr;
    sif.beeper_wr  = bw;
    sif.beeper_mux = cur_mux;
    sif.mode_sd    = cur_msd;
    model_step(d, wr, bw, cur_mux, cur_msd);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle('0, '0, 1'b0);
  endtask

  // High counts over one full 512-clk period of steady input
  task automatic window(output int hl, output int hr, output bit cons_r);
    bit pr;
    hl = 0; hr = 0; cons_r = 0; pr = 0;
    for (int k = 0; k < TOP; k++) begin
      idle(1);
      if (sif.snd_l) hl++;
      if (sif.snd_r) begin
        hr++;
        if (pr) cons_r = 1;
      end
      pr = sif.snd_r;
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic drive_idle_inputs();
    sif.din = '0; sif.ch_wr = '0; sif.beeper_wr = 1'b0;
    sif.beeper_mux = cur_mux; sif.mode_sd = cur_msd;
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("cycle_out", int'({sif.snd_l, sif.snd_r, sif.beep_act}), int'(mon_e));
    end
  end

  initial begin
    int hl, hr;
    bit cons;
    logic [DW-1:0]  d;
    logic [NCH-1:0] wr;
    logic           bw;

    rst_n = 1'b0;
    cur_mux = 1'b0;
    cur_msd = 1'b0;
    drive_idle_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1 check("reset_out", int'({sif.snd_l, sif.snd_r, sif.beep_act}), 0);
    release_reset();

    // PWM on the left: 0x80 + 0x80 = 256 of 512
    cycle(8'h80, 4'b0001, 1'b0);
    cycle(8'h80, 4'b0100, 1'b0);
    idle(5);
    window(hl, hr, cons);
    check("pwm_l_count", hl, 256);
    check("pwm_r_count", hr, 0);

    // Sigma-delta on the right: 64 of 512, never two highs in a row
    cycle(8'h40, 4'b0010, 1'b0);
    cycle(8'h00, 4'b1000, 1'b0);
    cur_msd = 1'b1;
    idle(TOP + 8);
    window(hl, hr, cons);
    check("sd_r_count", hr, 64);
    check("sd_r_consec", int'(cons), 0);
    check("sd_l_count", hl, 256);

    // Back to PWM, then request SD at ctr=100; takes effect only at the wrap
    cur_msd = 1'b0;
    idle(TOP + 8);
    for (int k = 0; k < TOP && m_ctr != 100; k++) idle(1);
    cur_msd = 1'b1;
    idle(TOP + 20);
    cur_msd = 1'b0;
    idle(TOP + 8);

    // Beeper: changing bit enters beeper mode with full-scale outputs
    cur_mux = 1'b0;
    cycle(8'h10, '0, 1'b1);
    idle(1);
    check("beep_enter", int'(sif.beep_act), 1);
    idle(3);
    window(hl, hr, cons);
    check("beep_l_count", hl, TOP - 1);
    check("beep_r_count", hr, TOP - 1);
    cycle(8'h80, 4'b0001, 1'b0);
    idle(1);
    check("beep_leave", int'(sif.beep_act), 0);

    // Priority: changing beeper write with a channel write; beeper wins, sample loads
    cycle(8'h2C, 4'b0010, 1'b1);
    idle(1);
    check("prio_act", int'(sif.beep_act), 1);
    cycle(8'h00, '0, 1'b1);
    idle(1);
    check("same_bit_hold", int'(sif.beep_act), 1);
    cycle(8'h00, 4'b1000, 1'b0);
    idle(4);
    check("prio_leave", int'(sif.beep_act), 0);
    window(hl, hr, cons);
    check("prio_r_count", hr, 44);
    check("prio_l_count", hl, 256);

    // Tapeout source selection
    cur_mux = 1'b1;
    cycle(8'h08, '0, 1'b1);
    idle(1);
    check("tape_enter", int'(sif.beep_act), 1);

    // Randomized traffic against the model
    for (int k = 0; k < 6000; k++) begin
      d  = DW'($urandom);
      wr = '0;
      for (int i = 0; i < NCH; i++) if ($urandom_range(0, 15) == 0) wr[i] = 1'b1;
      bw = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 29) == 0)  cur_mux = ~cur_mux;
      if ($urandom_range(0, 399) == 0) cur_msd = ~cur_msd;
      cycle(d, wr, bw);
    end

    // Reset mid-activity: outputs clear at once and stay quiet with all samples zero
    cycle(8'hFF, 4'b1111, 1'b0);
    #2 rst_n = 1'b0;
    exp_q.delete();
    model_reset();
    cur_msd = 1'b0;
    drive_idle_inputs();
    #1 check("async_reset", int'({sif.snd_l, sif.snd_r, sif.beep_act}), 0);
    repeat (3) @(posedge clk);
    release_reset();
    idle(5);
    window(hl, hr, cons);
    check("post_reset_l", hl, 0);
    check("post_reset_r", hr, 0);

    @(posedge clk);
    #3 check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
